regfile_bypass: RTL and testbench



---
 rtl/regfile_bypass_if.sv | 25 ++
 rtl/regfile_bypass.sv | 56 +++++
 tb/tb_regfile_bypass.sv | 127 ++++++++++++
 3 files changed

// File: rtl/regfile_bypass_if.sv
// Register-file port bundle: writeback-stage write port, two decode read ports, and the err flag.
// The master drives selects and write data; the slave (register file) returns read data and err.
interface regfile_bypass_if #(
  parameter int N     = 16,
  parameter int SEL_W = 3
);
  logic [SEL_W-1:0] read1RegSel;
  logic [SEL_W-1:0] read2RegSel;
  logic [SEL_W-1:0] writeRegSel;
  logic [N-1:0]     writeData;
  logic             writeEn;
  logic [N-1:0]     read1Data;
  logic [N-1:0]     read2Data;
  logic             err;

  modport master (
    output read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
    input  read1Data, read2Data, err
  );

  modport slave (
    input  read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
    output read1Data, read2Data, err
  );
endinterface

// File: rtl/regfile_bypass.sv
// 8 x 16-bit architectural register file with same-cycle write-to-read bypass.
// Reads are combinational; a write is visible on a matching read port in its own cycle.
module regfile_bypass #(
  parameter int N        = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) (
  input  logic            clk,
  input  logic            rst,
  regfile_bypass_if.slave rf
);

  logic [N-1:0] w_regs [NUM_REGS];
  logic [N-1:0] w_read1_store;
  logic [N-1:0] w_read2_store;
  logic         w_bypass1;
  logic         w_bypass2;
  logic         r_err;

  // One independent register per index, each with its own decoded load enable.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [N-1:0] r_data;
      logic         w_load;

      assign w_load = rf.writeEn && (rf.writeRegSel == SEL_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          r_data <= '0;
        end else if (w_load) begin
          r_data <= rf.writeData;
        end
      end

      assign w_regs[gi] = r_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    r_err <= rf.writeEn & rst;
  end

  assign w_read1_store = w_regs[rf.read1RegSel];
  assign w_read2_store = w_regs[rf.read2RegSel];

  // Bypass is blocked during reset because the write itself is being dropped.
  assign w_bypass1 = rf.writeEn && !rst && (rf.writeRegSel == rf.read1RegSel);
  assign w_bypass2 = rf.writeEn && !rst && (rf.writeRegSel == rf.read2RegSel);

  assign rf.read1Data = w_bypass1 ? rf.writeData : w_read1_store;
  assign rf.read2Data = w_bypass2 ? rf.writeData : w_read2_store;
  assign rf.err       = r_err;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed plus random bench for regfile_bypass against an array-based register model.
// Every cycle compares both read ports and err against the model before the clock edge.
module tb_regfile_bypass;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [15:0] model [8];
  logic        err_exp;

  regfile_bypass_if #(.N(16), .SEL_W(3)) rf ();

  regfile_bypass #(.N(16), .NUM_REGS(8), .SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input string tag, input logic rst_v, input logic we,
                      input logic [2:0] wsel, input logic [15:0] wdata,
                      input logic [2:0] r1, input logic [2:0] r2);
    logic [15:0] exp1;
    logic [15:0] exp2;
    rst            = rst_v;
    rf.writeEn     = we;
    rf.writeRegSel = wsel;
    rf.writeData   = wdata;
    rf.read1RegSel = r1;
    rf.read2RegSel = r2;
    #2;
    exp1 = (we && !rst_v && wsel == r1) ? wdata : model[r1];
    exp2 = (we && !rst_v && wsel == r2) ? wdata : model[r2];
    check({tag, ".rd1"}, rf.read1Data, exp1);
    check({tag, ".rd2"}, rf.read2Data, exp2);
    check({tag, ".err"}, {15'd0, rf.err}, {15'd0, err_exp});
    $display("%s: rst=%0b we=%0b w[%0d]=%h r1[%0d]=%h r2[%0d]=%h err=%0b",
             tag, rst_v, we, wsel, wdata, r1, rf.read1Data, r2, rf.read2Data, rf.err);
    @(posedge clk);
    if (rst_v) begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    end else if (we) begin
      model[wsel] = wdata;
    end
    err_exp = we & rst_v;
    #1;
  endtask

  initial begin
    logic        rv;
    logic        we;
    logic [2:0]  ws;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [15:0] wd;
    errors = 0;
    checks = 0;

    // First reset cycle: storage is unknown, so nothing is compared yet.
    rst = 1'b1;
    rf.writeEn = 1'b0;
    rf.writeRegSel = 3'd0;
    rf.writeData = 16'h0000;
    rf.read1RegSel = 3'd0;
    rf.read2RegSel = 3'd0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    err_exp = 1'b0;

    step("reset2", 1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd7);
    for (int k = 0; k < 8; k++)
      step("rst_sweep", 1'b0, 1'b0, 3'd0, 16'h0000, 3'(k), 3'(7 - k));

    step("wr_r3", 1'b0, 1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd1);
    step("rd_r3", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd4);

    step("byp_r5", 1'b0, 1'b1, 3'd5, 16'h1234, 3'd5, 3'd5);
    step("hold_r5", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd5);

    step("wr_r2_old", 1'b0, 1'b1, 3'd2, 16'h00AA, 3'd0, 3'd0);
    step("byp_r2", 1'b0, 1'b1, 3'd2, 16'h5555, 3'd2, 3'd6);
    step("wr_r6_rd2", 1'b0, 1'b1, 3'd6, 16'h7777, 3'd2, 3'd6);
    step("b2b_r6a", 1'b0, 1'b1, 3'd6, 16'h1111, 3'd2, 3'd6);
    step("b2b_r6b", 1'b0, 1'b1, 3'd6, 16'h2222, 3'd6, 3'd2);
    step("rd_r6", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd2);

    step("wr_r1", 1'b0, 1'b1, 3'd1, 16'hCAFE, 3'd0, 3'd0);
    step("rst_wr", 1'b1, 1'b1, 3'd1, 16'hFFFF, 3'd1, 3'd1);
    step("after_rst", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd3);
    step("err_clr", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd5);

    for (int k = 0; k < 8; k++)
      step("sweep_wr", 1'b0, 1'b1, 3'(k), 16'h1000 + 16'(k), 3'd0, 3'd7);
    for (int k = 0; k < 8; k++)
      step("sweep_rd", 1'b0, 1'b0, 3'd0, 16'h0000, 3'(k), 3'(7 - k));

    for (int n = 0; n < 300; n++) begin
      rv = ($urandom_range(0, 19) == 0);
      we = 1'($urandom_range(0, 1));
      ws = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      s1 = 3'($urandom_range(0, 7));
      s2 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) s1 = ws;
      if ($urandom_range(0, 3) == 0) s2 = ws;
      step("rand", rv, we, ws, wd, s1, s2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
